// File: rtl/hdlc_line_monitor.sv
// rtl/hdlc_line_monitor.sv - multi-channel HDLC receive-line monitor with frame checks and error counter
module hdlc_line_monitor #(
    parameter int NUM_CH    = 1,
    parameter int MAX_BYTES = 128,
    parameter int MIN_BYTES = 3,
    parameter int SIZE_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_CH-1:0]        Rx,
    input  logic [NUM_CH-1:0]        RxEn,
    input  logic                     ErrClr,
    output logic [NUM_CH-1:0]        FlagDetect,
    output logic [NUM_CH-1:0]        AbortDetect,
    output logic [NUM_CH-1:0]        IdleDetect,
    output logic [NUM_CH-1:0]        FrameValid,
    output logic [NUM_CH-1:0]        FrameDone,
    output logic [NUM_CH*SIZE_W-1:0] FrameSize,
    output logic [NUM_CH*4-1:0]      ErrFlags,
    output logic [CNT_W-1:0]         ErrCount
);
    typedef enum logic {HUNT, OPEN} state_t;

    localparam int HI_W = SIZE_W + 1;
    localparam logic [HI_W-1:0]   HI_SAT   = HI_W'(MAX_BYTES + 2);
    localparam logic [HI_W-1:0]   HI_MAXP1 = HI_W'(MAX_BYTES + 1);
    localparam logic [SIZE_W-1:0] SZ_MAX   = SIZE_W'(MAX_BYTES);
    localparam logic [SIZE_W-1:0] SZ_MIN   = SIZE_W'(MIN_BYTES);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t            state, state_nxt;
        logic [7:0]        sr, sr_nxt;
        logic [3:0]        ones, ones_nxt;
        logic [2:0]        lo, lo_nxt, k, pay_lo;
        logic [HI_W-1:0]   hi, hi_nxt, pay_hi;
        logic              is_flag, is_abort, stuffed, has_pay, close;
        logic [SIZE_W-1:0] nbytes;
        logic [3:0]        err;
        logic              ev_flag, ev_abort, ev_done;
        logic [SIZE_W-1:0] ev_size, size_q;
        logic [3:0]        ev_err, err_q;
        logic              flag_q, abort_q, idle_q, valid_q, done_q;

        // {hi,lo} counts destuffed bits since the opening flag, including the
        // pattern bits already shifted in; the closing pattern is subtracted here.
        always_comb begin
            sr_nxt   = {Rx[c], sr[7:1]};
            is_flag  = (sr_nxt == 8'h7E);
            is_abort = (sr_nxt == 8'hFE);
            stuffed  = !Rx[c] && (ones == 4'd5);
            if (!Rx[c])            ones_nxt = 4'd0;
            else if (ones == 4'd8) ones_nxt = ones;
            else                   ones_nxt = ones + 4'd1;
            k       = is_abort ? 3'd6 : 3'd7;
            pay_lo  = lo - k;
            pay_hi  = hi - ((lo < k) ? HI_W'(1) : HI_W'(0));
            has_pay = (hi != '0) || (lo > k);
            if (!has_pay)                nbytes = '0;
            else if (pay_hi > HI_MAXP1) nbytes = HI_MAXP1[SIZE_W-1:0];
            else                         nbytes = pay_hi[SIZE_W-1:0];
            err = {is_abort, nbytes > SZ_MAX, !is_abort && (nbytes < SZ_MIN), pay_lo != 3'd0};

            state_nxt = state;
            lo_nxt    = lo;
            hi_nxt    = hi;
            close     = 1'b0;
            if (RxEn[c]) begin
                case (state)
                    HUNT: begin
                        if (is_flag) begin
                            state_nxt = OPEN;
                            lo_nxt    = '0;
                            hi_nxt    = '0;
                        end
                    end
                    OPEN: begin
                        if (is_flag || is_abort) begin
                            close  = has_pay;
                            lo_nxt = '0;
                            hi_nxt = '0;
                            if (is_abort) state_nxt = HUNT;
                        end else if (!stuffed) begin
                            lo_nxt = lo + 3'd1;
                            if (lo == 3'd7 && hi != HI_SAT) hi_nxt = hi + HI_W'(1);
                        end
                    end
                    default: state_nxt = HUNT;
                endcase
            end
        end

        always_ff @(posedge Clk) begin
            if (Rst) begin
                state    <= HUNT;
                sr       <= '0;
                ones     <= '0;
                lo       <= '0;
                hi       <= '0;
                ev_flag  <= 1'b0;
                ev_abort <= 1'b0;
                ev_done  <= 1'b0;
                ev_size  <= '0;
                ev_err   <= '0;
            end else begin
                state    <= state_nxt;
                lo       <= lo_nxt;
                hi       <= hi_nxt;
                ev_flag  <= RxEn[c] && is_flag;
                ev_abort <= RxEn[c] && is_abort;
                ev_done  <= close;
                if (close) begin
                    ev_size <= nbytes;
                    ev_err  <= err;
                end
                if (RxEn[c]) begin
                    sr   <= sr_nxt;
                    ones <= ones_nxt;
                end
            end
        end

        // Output stage: the second register gives the two-edge event latency.
        always_ff @(posedge Clk) begin
            if (Rst) begin
                flag_q  <= 1'b0;
                abort_q <= 1'b0;
                idle_q  <= 1'b0;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
                size_q  <= '0;
                err_q   <= '0;
            end else begin
                flag_q  <= ev_flag;
                abort_q <= ev_abort;
                idle_q  <= (ones >= 4'd8);
                valid_q <= (state == OPEN);
                done_q  <= ev_done;
                if (ev_done) begin
                    size_q <= ev_size;
                    err_q  <= ev_err;
                end
            end
        end

        assign FlagDetect[c]                 = flag_q;
        assign AbortDetect[c]                = abort_q;
        assign IdleDetect[c]                 = idle_q;
        assign FrameValid[c]                 = valid_q;
        assign FrameDone[c]                  = done_q;
        assign FrameSize[c*SIZE_W +: SIZE_W] = size_q;
        assign ErrFlags[c*4 +: 4]            = err_q;
    end

    logic [CNT_W-1:0] n_err;
    logic [CNT_W:0]   err_sum;

    always_comb begin
        n_err = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (FrameDone[i] && (ErrFlags[i*4 +: 4] != 4'd0)) n_err = n_err + CNT_W'(1);
        err_sum = {1'b0, ErrCount} + {1'b0, n_err};
    end

    always_ff @(posedge Clk) begin
        if (Rst || ErrClr)      ErrCount <= '0;
        else if (err_sum[CNT_W]) ErrCount <= '1;
        else                     ErrCount <= err_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_hdlc_line_monitor.sv
// tb/tb_hdlc_line_monitor.sv - directed table-driven bench for hdlc_line_monitor
module tb_hdlc_line_monitor;
    localparam int NUM_CH = 4, MAX_BYTES = 8, MIN_BYTES = 3, SIZE_W = 8, CNT_W = 16;

    logic                     Clk = 1'b0;
    logic                     Rst, ErrClr;
    logic [NUM_CH-1:0]        Rx, RxEn;
    logic [NUM_CH-1:0]        FlagDetect, AbortDetect, IdleDetect, FrameValid, FrameDone;
    logic [NUM_CH*SIZE_W-1:0] FrameSize;
    logic [NUM_CH*4-1:0]      ErrFlags;
    logic [CNT_W-1:0]         ErrCount;

    hdlc_line_monitor #(.NUM_CH(NUM_CH), .MAX_BYTES(MAX_BYTES), .MIN_BYTES(MIN_BYTES),
                        .SIZE_W(SIZE_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEn(RxEn), .ErrClr(ErrClr),
        .FlagDetect(FlagDetect), .AbortDetect(AbortDetect), .IdleDetect(IdleDetect),
        .FrameValid(FrameValid), .FrameDone(FrameDone), .FrameSize(FrameSize),
        .ErrFlags(ErrFlags), .ErrCount(ErrCount)
    );

    always #5 Clk = ~Clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int               done_cnt[NUM_CH]      = '{default: 0};
    int               done_cyc[NUM_CH]      = '{default: 0};
    int               flag_cyc[NUM_CH]      = '{default: 0};
    int               abort_cyc[NUM_CH]     = '{default: 0};
    logic [SIZE_W-1:0] last_size[NUM_CH]    = '{default: '0};
    logic [3:0]        last_err[NUM_CH]     = '{default: '0};
    logic              valid_at_flag[NUM_CH] = '{default: 1'b0};

    always @(negedge Clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (FrameDone[c]) begin
                done_cnt[c]  = done_cnt[c] + 1;
                done_cyc[c]  = cyc;
                last_size[c] = FrameSize[c*SIZE_W +: SIZE_W];
                last_err[c]  = ErrFlags[c*4 +: 4];
            end
            if (FlagDetect[c]) begin
                flag_cyc[c]      = cyc;
                valid_at_flag[c] = FrameValid[c];
            end
            if (AbortDetect[c]) abort_cyc[c] = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic stream [NUM_CH][0:2047];
    int   slen[NUM_CH]     = '{default: 0};
    int   tx_ones[NUM_CH]  = '{default: 0};
    int   last_cyc[NUM_CH] = '{default: 0};

    task automatic push_bit(input int c, input logic b, input bit stuff);
        stream[c][slen[c]] = b;
        slen[c]++;
        tx_ones[c] = b ? tx_ones[c] + 1 : 0;
        if (stuff && tx_ones[c] == 5) begin
            stream[c][slen[c]] = 1'b0;
            slen[c]++;
            tx_ones[c] = 0;
        end
    endtask

    task automatic push_flag(input int c);
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) push_bit(c, f[i], 1'b0);
    endtask

    task automatic push_byte(input int c, input logic [7:0] d);
        for (int i = 0; i < 8; i++) push_bit(c, d[i], 1'b1);
    endtask

    // Plays all queued streams in parallel; optional idle gap after each bit
    // and optional ErrClr pulse in the cycle a frame closing at the end shows FrameDone.
    task automatic play(input bit gap, input bit clr);
        int n;
        n = 0;
        for (int c = 0; c < NUM_CH; c++) if (slen[c] > n) n = slen[c];
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                Rx[c]   = (i < slen[c]) ? stream[c][i] : 1'b1;
                RxEn[c] = (i < slen[c]);
                if (i == slen[c] - 1) last_cyc[c] = cyc;
            end
            @(posedge Clk); #1;
            if (gap) begin
                RxEn = '0;
                Rx   = ~Rx;
                @(posedge Clk); #1;
            end
        end
        RxEn = '0;
        if (clr) begin
            @(posedge Clk); #1;
            ErrClr = 1'b1;
            @(posedge Clk); #1;
            ErrClr = 1'b0;
        end
        repeat (4) @(posedge Clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) slen[c] = 0;
    endtask

    typedef struct {
        int          ch;
        int          nbytes;
        logic [95:0] data;
        int          tail;
        bit          gap;
        logic [7:0]  exp_size;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t vecs[9];
    int   exp_cnt = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c, d0, d1, d3;

        // ErrFlags = {ABORT, OVERFLOW, SHORT, ALIGN}; MAX_BYTES=8, MIN_BYTES=3
        vecs[0] = '{0,  4, 96'h55AA01FF,             0, 1'b0, 8'd4, 4'b0000};
        vecs[1] = '{0,  2, 96'h00C3A5,               1, 1'b0, 8'd2, 4'b0011};
        vecs[2] = '{2, 10, 96'hFF870F1E2D3C4B5A6978, 0, 1'b0, 8'd9, 4'b0100};
        vecs[3] = '{2,  3, 96'h7EFF81,               0, 1'b0, 8'd3, 4'b0000};
        vecs[4] = '{1,  8, 96'h0123456789ABCDEF,     0, 1'b1, 8'd8, 4'b0000};
        vecs[5] = '{3,  9, 96'hFFFFFFFFFFFFFFFFFF,   0, 1'b0, 8'd9, 4'b0100};
        vecs[6] = '{1,  2, 96'h3C3C,                 0, 1'b0, 8'd2, 4'b0010};
        vecs[7] = '{0,  3, 96'h0F6699E7,             5, 1'b0, 8'd3, 4'b0001};
        vecs[8] = '{3,  0, 96'h5,                    3, 1'b0, 8'd0, 4'b0011};

        Rst = 1'b1; ErrClr = 1'b0; Rx = '0; RxEn = '0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(posedge Clk); #1;
        chk("reset FlagDetect",  32'(FlagDetect), 0);
        chk("reset AbortDetect", 32'(AbortDetect), 0);
        chk("reset IdleDetect",  32'(IdleDetect), 0);
        chk("reset FrameValid",  32'(FrameValid), 0);
        chk("reset FrameDone",   32'(FrameDone), 0);
        chk("reset FrameSize",   FrameSize, 0);
        chk("reset ErrFlags",    32'(ErrFlags), 0);
        chk("reset ErrCount",    32'(ErrCount), 0);

        // Idle line then opening flag on ch0
        for (int i = 0; i < 16; i++) push_bit(0, 1'b1, 1'b0);
        play(1'b0, 1'b0);
        chk("idle level", 32'(IdleDetect[0]), 1);
        chk("idle hunt valid", 32'(FrameValid[0]), 0);
        push_flag(0);
        play(1'b0, 1'b0);
        chk("flag latency", flag_cyc[0], last_cyc[0] + 2);
        chk("valid with flag", 32'(valid_at_flag[0]), 1);
        chk("idle cleared", 32'(IdleDetect[0]), 0);
        chk("open valid", 32'(FrameValid[0]), 1);
        chk("open no done", done_cnt[0], 0);

        for (int i = 0; i < 9; i++) begin
            c  = vecs[i].ch;
            d0 = done_cnt[c];
            push_flag(c);
            for (int b = 0; b < vecs[i].nbytes * 8 + vecs[i].tail; b++)
                push_bit(c, vecs[i].data[b], 1'b1);
            push_flag(c);
            play(vecs[i].gap, 1'b0);
            if (vecs[i].exp_err != 4'd0) exp_cnt++;
            chk($sformatf("v%0d done count", i), done_cnt[c] - d0, 1);
            chk($sformatf("v%0d size", i), 32'(last_size[c]), 32'(vecs[i].exp_size));
            chk($sformatf("v%0d errflags", i), 32'(last_err[c]), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d errcount", i), 32'(ErrCount), exp_cnt);
        end

        // Abort after two bytes on ch0
        d0 = done_cnt[0];
        push_flag(0);
        push_byte(0, 8'h12);
        push_byte(0, 8'h34);
        push_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) push_bit(0, 1'b1, 1'b0);
        play(1'b0, 1'b0);
        exp_cnt++;
        chk("abort done", done_cnt[0] - d0, 1);
        chk("abort aligned", abort_cyc[0], done_cyc[0]);
        chk("abort flags", 32'(last_err[0] & 4'b1110), 32'(4'b1000));
        chk("abort size", 32'(last_size[0]), 2);
        chk("abort hunt", 32'(FrameValid[0]), 0);
        chk("abort errcount", 32'(ErrCount), exp_cnt);
        push_byte(0, 8'h12);
        push_byte(0, 8'h34);
        push_byte(0, 8'hFF);
        play(1'b0, 1'b0);
        chk("hunt no done", done_cnt[0] - d0, 1);
        chk("hunt still invalid", 32'(FrameValid[0]), 0);

        // Simultaneous errored closes on ch1 and ch3
        d1 = done_cnt[1]; d3 = done_cnt[3];
        for (int j = 1; j < 4; j += 2) begin
            push_flag(j); push_byte(j, 8'h5A); push_flag(j);
        end
        play(1'b0, 1'b0);
        exp_cnt += 2;
        chk("dual same cycle", done_cyc[1], done_cyc[3]);
        chk("dual done ch1", done_cnt[1] - d1, 1);
        chk("dual done ch3", done_cnt[3] - d3, 1);
        chk("dual errcount", 32'(ErrCount), exp_cnt);

        // ErrClr coinciding with errored closes
        d1 = done_cnt[1];
        for (int j = 1; j < 4; j += 2) begin
            push_flag(j); push_byte(j, 8'h5A); push_flag(j);
        end
        play(1'b0, 1'b1);
        exp_cnt = 0;
        chk("clr close cycle", done_cyc[1], last_cyc[1] + 2);
        chk("clr done ch1", done_cnt[1] - d1, 1);
        chk("clr errcount", 32'(ErrCount), exp_cnt);

        // Reset in the middle of a frame on ch2
        d0 = done_cnt[2];
        push_flag(2);
        push_byte(2, 8'h33);
        play(1'b0, 1'b0);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        chk("rst FrameValid", 32'(FrameValid), 0);
        chk("rst FrameSize", FrameSize, 0);
        chk("rst ErrFlags", 32'(ErrFlags), 0);
        chk("rst ErrCount", 32'(ErrCount), 0);
        push_byte(2, 8'h44);
        push_flag(2);
        play(1'b0, 1'b0);
        chk("rst no done", done_cnt[2] - d0, 0);
        chk("rst reopen", 32'(FrameValid[2]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hdlc_line_monitor.md
Name: hdlc_line_monitor

Overview:
- Synthesizable, parametrised multi-channel HDLC receive-line monitor.
- Generalises the Rx protocol checks (flag, abort, idle, zero removal, frame size, overflow, alignment) from simulation-only checks into RTL.
- Sits beside the Rx datapath on each serial line, or on N lines in a multi-link build.
- Reports per-channel events and frame status, plus one saturating aggregate error counter readable by software.

Parameters:
NUM_CH, 1, number of independent serial channels
MAX_BYTES, 128, largest legal payload byte count per frame (FCS included)
MIN_BYTES, 3, smallest legal payload byte count per frame
SIZE_W, 8, width of each FrameSize field; must hold MAX_BYTES+1
CNT_W, 16, width of ErrCount

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  synchronous, active-high reset
Rx  in  NUM_CH  serial data, one bit per channel, LSB-first
RxEn  in  NUM_CH  per-channel bit strobe; Rx[c] is sampled only when RxEn[c]=1
ErrClr  in  1  synchronous clear of ErrCount
FlagDetect  out  NUM_CH  1-cycle pulse: flag 0x7E received
AbortDetect  out  NUM_CH  1-cycle pulse: 0 followed by 7 ones received
IdleDetect  out  NUM_CH  level: at least 8 consecutive ones since the last 0
FrameValid  out  NUM_CH  level: channel is between opening and closing flag
FrameDone  out  NUM_CH  1-cycle pulse: frame closed by flag or abort
FrameSize  out  NUM_CH*SIZE_W  payload bytes of last frame, valid with FrameDone
ErrFlags  out  NUM_CH*4  {ABORT,OVERFLOW,SHORT,ALIGN}, valid with FrameDone
ErrCount  out  CNT_W  saturating count of errored frames, all channels

Behaviour:
- Reset: all outputs 0; every channel goes to HUNT with its shift register, ones counter, bit counter and byte counter cleared.
- Reset during a frame discards that frame silently; no FrameDone is produced.
- RxEn[c]=0: channel c state is frozen and no events fire. Channels are fully independent.
- Per channel, on each enabled sample:
  - An 8-bit shift register takes the new bit at the MSB (shift right).
  - ones counter = consecutive 1s, saturating at 8.
- Decode on the enabled sample, using the updated shift register:
  - flag = 0x7E.
  - abort = 0xFE (the 7th one after a 0; fires once per run).
  - idle = ones counter >= 8.
- Latency: the decode is registered, so FlagDetect and AbortDetect are high during the cycle that starts 2 edges after the last pattern bit is on Rx. FrameDone, FrameSize and ErrFlags are aligned with the FlagDetect/AbortDetect pulse that closes the frame.
- States:
  - HUNT: FrameValid=0. flag -> OPEN. abort -> pulse only, stay in HUNT.
  - OPEN: FrameValid=1; destuffed payload bits are counted.
    - Zero removal: a 0 received when the ones counter = 5 is dropped, not counted.
    - flag with payload bits = 0: shared or back-to-back flag, stay in OPEN, no FrameDone.
    - flag with payload bits > 0: FrameDone, counters cleared, stay in OPEN.
    - abort: FrameDone with ABORT set only if payload bits > 0; go to HUNT either way.
- Payload bit count excludes all 8 bits of the closing flag (and the 7 abort bits).
- Payload byte count = bits/8, saturating at MAX_BYTES+1.
- Error flags at frame close:
  - ALIGN = bits%8 != 0.
  - SHORT = bytes < MIN_BYTES (not evaluated on abort).
  - OVERFLOW = bytes > MAX_BYTES.
  - Several flags may be set together.
- FrameSize = saturated byte count. FrameSize and ErrFlags hold until the next FrameDone on that channel.
- ErrCount:
  - Adds the number of channels whose FrameDone pulse has any ErrFlags bit set, in the same cycle.
  - Saturates at all-ones.
  - ErrClr=1 forces 0; increments in that same cycle are dropped.

Test Plan:
- Idle 16 ones, then 0x7E on ch0 -> IdleDetect=1 before the flag; FlagDetect pulses exactly 2 edges after the final 0; FrameValid rises with it.
- Flag, payload 0xFF 0x01 0xAA 0x55 (stuffed zeros inserted), flag -> FrameDone with FrameSize=4, ErrFlags=0, ErrCount unchanged.
- Flag, 17 payload bits, flag -> ALIGN set, FrameSize=2, SHORT set (MIN_BYTES=3), ErrCount=1.
- MAX_BYTES=8: flag, 10 bytes, flag -> FrameSize=9, OVERFLOW set. Next frame of 3 bytes -> ErrFlags=0.
- Flag, 2 bytes, 0 then 7 ones -> AbortDetect and FrameDone with ABORT set, channel in HUNT (FrameValid=0). Further data before the next flag produces no FrameDone.
- NUM_CH=4: errored frames close on ch1 and ch3 in the same cycle -> ErrCount += 2. ErrClr in a cycle with an error close -> ErrCount=0. Rst mid-frame -> all outputs 0, no FrameDone.
